// File: rtl/tmp_readout_if.sv
// Readout handshake bundle: front-end strobes in, temperature code out.
// The slave side is the readout block; the master side is the sequencer/host environment.
interface tmp_readout_if #(
  parameter int unsigned DATA_W = 16
);
  logic              enable;
  logic              src_evt;
  logic              snk_evt;
  logic              conv_done;
  logic              code_ready;
  logic [DATA_W-1:0] code;
  logic              code_valid;
  logic              overrun;
  logic              busy;

  modport master (
    output enable, src_evt, snk_evt, conv_done, code_ready,
    input  code, code_valid, overrun, busy
  );

  modport slave (
    input  enable, src_evt, snk_evt, conv_done, code_ready,
    output code, code_valid, overrun, busy
  );
endinterface

// File: rtl/tmp_readout.sv
// Charge-balance temperature readout: saturating per-frame up/down count,
// windowed sum over 2^LOG_WIN frames, delivered through a valid/ready register.
module tmp_readout #(
  parameter int unsigned CNT_W   = 12,
  parameter int unsigned LOG_WIN = 4,
  parameter int unsigned DATA_W  = CNT_W + LOG_WIN
) (
  input  logic         clk,
  input  logic         reset,
  tmp_readout_if.slave bus
);

  localparam int unsigned ACC_W = CNT_W + LOG_WIN;
  localparam int unsigned CW1   = CNT_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SYNC = 2'd1;
  localparam logic [1:0] S_ACC  = 2'd2;

  localparam int                    CNT_MAX_I = (1 << (CNT_W - 1)) - 1;
  localparam logic signed [CW1-1:0] CNT_MAX   = CW1'(CNT_MAX_I);
  localparam logic signed [CW1-1:0] CNT_MIN   = CW1'(-CNT_MAX_I);

  logic [1:0]               r_state, w_state_nx;
  logic signed [CNT_W-1:0]  r_cnt, w_cnt_nx, w_frame;
  logic signed [CW1-1:0]    w_delta, w_cnt_wide;
  logic signed [ACC_W-1:0]  r_acc, w_acc_nx, w_acc_sum;
  logic [LOG_WIN-1:0]       r_idx, w_idx_nx;
  logic                     w_win_done;
  logic [DATA_W-1:0]        r_code, w_code_nx;
  logic                     r_code_valid, w_valid_nx;
  logic                     r_overrun, w_ovr_nx;
  logic                     r_busy;

  // Event delta and saturated running count; also the closing-frame value on conv_done
  always_comb begin
    w_delta = '0;
    if (bus.src_evt && !bus.snk_evt) begin
      w_delta = CW1'(1);
    end else if (!bus.src_evt && bus.snk_evt) begin
      w_delta = CW1'(-1);
    end
    w_cnt_wide = CW1'(r_cnt) + w_delta;
    if (w_cnt_wide > CNT_MAX) begin
      w_frame = CNT_W'(CNT_MAX);
    end else if (w_cnt_wide < CNT_MIN) begin
      w_frame = CNT_W'(CNT_MIN);
    end else begin
      w_frame = CNT_W'(w_cnt_wide);
    end
    w_acc_sum = r_acc + ACC_W'(w_frame);
  end

  // Next state and window bookkeeping
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_acc_nx   = r_acc;
    w_idx_nx   = r_idx;
    w_win_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        w_acc_nx = '0;
        w_idx_nx = '0;
        if (bus.enable) w_state_nx = S_SYNC;
      end
      S_SYNC: begin
        w_cnt_nx = '0;
        w_acc_nx = '0;
        w_idx_nx = '0;
        if (!bus.enable) begin
          w_state_nx = S_IDLE;
        end else if (bus.conv_done) begin
          w_state_nx = S_ACC;
        end
      end
      S_ACC: begin
        if (!bus.enable) begin
          w_state_nx = S_IDLE;
          w_cnt_nx   = '0;
          w_acc_nx   = '0;
          w_idx_nx   = '0;
        end else if (bus.conv_done) begin
          w_cnt_nx = '0;
          if (r_idx == '1) begin
            w_win_done = 1'b1;
            w_acc_nx   = '0;
            w_idx_nx   = '0;
          end else begin
            w_acc_nx = w_acc_sum;
            w_idx_nx = r_idx + LOG_WIN'(1);
          end
        end else begin
          w_cnt_nx = w_frame;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
        w_acc_nx   = '0;
        w_idx_nx   = '0;
      end
    endcase
  end

  // Result register: a completed window replaces the code unless an unread one is held
  always_comb begin
    w_code_nx  = r_code;
    w_valid_nx = r_code_valid;
    w_ovr_nx   = r_overrun;
    if (w_win_done) begin
      if (!r_code_valid || bus.code_ready) begin
        w_code_nx  = DATA_W'(w_acc_sum);
        w_valid_nx = 1'b1;
      end else begin
        w_ovr_nx = 1'b1;
      end
    end else if (r_code_valid && bus.code_ready) begin
      w_valid_nx = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_acc        <= '0;
      r_idx        <= '0;
      r_code       <= '0;
      r_code_valid <= 1'b0;
      r_overrun    <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_state      <= w_state_nx;
      r_cnt        <= w_cnt_nx;
      r_acc        <= w_acc_nx;
      r_idx        <= w_idx_nx;
      r_code       <= w_code_nx;
      r_code_valid <= w_valid_nx;
      r_overrun    <= w_ovr_nx;
      r_busy       <= (w_state_nx != S_IDLE);
    end
  end

  assign bus.code       = r_code;
  assign bus.code_valid = r_code_valid;
  assign bus.overrun    = r_overrun;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_tmp_readout.sv
// Self-checking bench for tmp_readout: directed scenarios plus a randomized run,
// all checked against an integer-arithmetic model of windowed frame sums.
module tb_tmp_readout;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned LOG_WIN = 2;
  localparam int unsigned DATA_W  = 10;
  localparam int          WIN     = 4;
  localparam int          CMAX    = 127;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  tmp_readout_if #(.DATA_W(DATA_W)) bus ();

  tmp_readout #(.CNT_W(CNT_W), .LOG_WIN(LOG_WIN), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: running flag, sync-seen flag, open-frame count, closed frames of this window
  bit m_running, m_armed;
  int m_cur;
  int m_frames[$];
  int m_code;
  bit m_valid, m_ovr, m_busy;

  function automatic int clamp(input int v);
    if (v > CMAX) return CMAX;
    if (v < -CMAX) return -CMAX;
    return v;
  endfunction

  function automatic int dut_code();
    logic signed [DATA_W-1:0] c;
    c = bus.code;
    return int'(c);
  endfunction

  task automatic model_step();
    bit done;
    int res, v, d;
    done = 1'b0;
    res  = 0;
    if (reset) begin
      m_running = 0; m_armed = 0; m_cur = 0; m_frames.delete();
      m_code = 0; m_valid = 0; m_ovr = 0; m_busy = 0;
      return;
    end
    if (!m_running) begin
      if (bus.enable) begin
        m_running = 1; m_armed = 0; m_cur = 0; m_frames.delete();
      end
    end else if (!bus.enable) begin
      m_running = 0; m_armed = 0; m_cur = 0; m_frames.delete();
    end else if (!m_armed) begin
      if (bus.conv_done) m_armed = 1;
    end else begin
      d = int'(bus.src_evt) - int'(bus.snk_evt);
      v = clamp(m_cur + d);
      if (bus.conv_done) begin
        m_frames.push_back(v);
        m_cur = 0;
        if (m_frames.size() == WIN) begin
          done = 1'b1;
          foreach (m_frames[k]) res += m_frames[k];
          m_frames.delete();
        end
      end else begin
        m_cur = v;
      end
    end
    if (done) begin
      if (!m_valid || bus.code_ready) begin
        m_code  = res;
        m_valid = 1;
      end else begin
        m_ovr = 1;
      end
    end else if (m_valid && bus.code_ready) begin
      m_valid = 0;
    end
    m_busy = m_running;
  endtask

  task automatic tick(input bit en, src, snk, cd, rdy, rst);
    bus.enable = en; bus.src_evt = src; bus.snk_evt = snk;
    bus.conv_done = cd; bus.code_ready = rdy; reset = rst;
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic frame(input int ns, input int nk, input bit rdy_body, input bit rdy_cd);
    for (int i = 0; i < ns; i++) tick(1, 1, 0, 0, rdy_body, 0);
    for (int i = 0; i < nk; i++) tick(1, 0, 1, 0, rdy_body, 0);
    tick(1, 0, 0, 1, rdy_cd, 0);
  endtask

  task automatic test_reset();
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    n_checks += 4;
    if (dut_code() !== 0) begin n_errors++; $display("FAIL reset_code: got %0d exp 0", dut_code()); end
    if (bus.code_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b exp 0", bus.code_valid); end
    if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL reset_overrun: got %b exp 0", bus.overrun); end
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_basic();
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    for (int f = 0; f < WIN - 1; f++) frame(5, 2, 0, 0);
    for (int i = 0; i < 5; i++) tick(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) tick(1, 0, 1, 0, 0, 0);
    n_checks++;
    if (bus.code_valid !== 1'b0) begin n_errors++; $display("FAIL basic_early_valid: got %b exp 0", bus.code_valid); end
    tick(1, 0, 0, 1, 0, 0);
    n_checks += 3;
    if (bus.code_valid !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b exp 1", bus.code_valid); end
    if (dut_code() !== 12) begin n_errors++; $display("FAIL basic_code: got %0d exp 12", dut_code()); end
    if (dut_code() !== m_code) begin n_errors++; $display("FAIL basic_model: got %0d exp %0d", dut_code(), m_code); end
    tick(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (bus.code_valid !== 1'b0) begin n_errors++; $display("FAIL basic_read: got %b exp 0", bus.code_valid); end
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 0, 0);
    tick(1, 1, 0, 1, 0, 0);
    for (int i = 0; i < WIN - 1; i++) tick(1, 0, 0, 1, 0, 0);
    n_checks += 2;
    if (bus.code_valid !== 1'b1) begin n_errors++; $display("FAIL boundary_valid: got %b exp 1", bus.code_valid); end
    if (dut_code() !== 1) begin n_errors++; $display("FAIL boundary_code: got %0d exp 1", dut_code()); end
    tick(1, 0, 0, 0, 1, 0);
  endtask

  task automatic test_saturation();
    for (int f = 0; f < WIN; f++) frame(300, 0, 0, 0);
    n_checks += 3;
    if (bus.code_valid !== 1'b1) begin n_errors++; $display("FAIL sat_valid: got %b exp 1", bus.code_valid); end
    if (dut_code() !== 508) begin n_errors++; $display("FAIL sat_code: got %0d exp 508", dut_code()); end
    if (dut_code() !== m_code) begin n_errors++; $display("FAIL sat_model: got %0d exp %0d", dut_code(), m_code); end
    tick(1, 0, 0, 0, 1, 0);
  endtask

  task automatic test_sync_discard();
    int exp_sum, ns, nk;
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) tick(1, 1, 0, 0, 0, 0);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL sync_busy: got %b exp 1", bus.busy); end
    tick(1, 0, 0, 1, 0, 0);
    exp_sum = 0;
    for (int f = 0; f < WIN; f++) begin
      ns = int'($urandom_range(0, 15));
      nk = int'($urandom_range(0, 15));
      exp_sum += ns - nk;
      frame(ns, nk, 0, 0);
    end
    n_checks += 2;
    if (dut_code() !== exp_sum) begin n_errors++; $display("FAIL sync_code: got %0d exp %0d", dut_code(), exp_sum); end
    if (bus.code_valid !== 1'b1) begin n_errors++; $display("FAIL sync_valid: got %b exp 1", bus.code_valid); end
    tick(1, 0, 0, 0, 1, 0);
  endtask

  task automatic test_backpressure();
    int e1, e3, ns, nk;
    e1 = 0;
    for (int f = 0; f < WIN; f++) begin
      ns = int'($urandom_range(0, 20)); nk = int'($urandom_range(0, 20));
      e1 += ns - nk;
      frame(ns, nk, 0, 0);
    end
    n_checks += 2;
    if (dut_code() !== e1) begin n_errors++; $display("FAIL bp_first_code: got %0d exp %0d", dut_code(), e1); end
    if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL bp_early_overrun: got %b exp 0", bus.overrun); end
    for (int f = 0; f < WIN; f++) frame(int'($urandom_range(0, 20)), int'($urandom_range(0, 20)), 0, 0);
    n_checks += 3;
    if (dut_code() !== e1) begin n_errors++; $display("FAIL bp_retained: got %0d exp %0d", dut_code(), e1); end
    if (bus.code_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid: got %b exp 1", bus.code_valid); end
    if (bus.overrun !== 1'b1) begin n_errors++; $display("FAIL bp_overrun: got %b exp 1", bus.overrun); end
    e3 = 0;
    for (int f = 0; f < WIN; f++) begin
      ns = int'($urandom_range(0, 20)); nk = int'($urandom_range(0, 20));
      e3 += ns - nk;
      frame(ns, nk, 0, (f == WIN - 1));
    end
    n_checks += 3;
    if (bus.code_valid !== 1'b1) begin n_errors++; $display("FAIL bp_third_valid: got %b exp 1", bus.code_valid); end
    if (dut_code() !== e3) begin n_errors++; $display("FAIL bp_third_code: got %0d exp %0d", dut_code(), e3); end
    if (bus.overrun !== m_ovr) begin n_errors++; $display("FAIL bp_third_overrun: got %b exp %b", bus.overrun, m_ovr); end
    tick(1, 0, 0, 0, 1, 0);
    n_checks++;
    if (bus.code_valid !== 1'b0) begin n_errors++; $display("FAIL bp_drain: got %b exp 0", bus.code_valid); end
  endtask

  task automatic test_disable();
    tick(0, 0, 0, 0, 0, 1);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    frame(3, 1, 0, 0);
    frame(2, 0, 0, 0);
    n_checks++;
    if (bus.busy !== 1'b1) begin n_errors++; $display("FAIL dis_busy_run: got %b exp 1", bus.busy); end
    tick(0, 1, 0, 0, 0, 0);
    n_checks += 2;
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL dis_busy: got %b exp 0", bus.busy); end
    if (bus.code_valid !== 1'b0) begin n_errors++; $display("FAIL dis_valid: got %b exp 0", bus.code_valid); end
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 0, 0);
    n_checks++;
    if (bus.code_valid !== 1'b0) begin n_errors++; $display("FAIL dis_idle_valid: got %b exp 0", bus.code_valid); end
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 0, 0, 1, 0, 0);
    for (int f = 0; f < 2 * WIN; f++) frame(4, 1, 0, 0);
    n_checks += 2;
    if (bus.code_valid !== 1'b1) begin n_errors++; $display("FAIL dis_pend_valid: got %b exp 1", bus.code_valid); end
    if (bus.overrun !== 1'b1) begin n_errors++; $display("FAIL dis_pend_overrun: got %b exp 1", bus.overrun); end
    tick(1, 1, 0, 1, 1, 1);
    n_checks += 4;
    if (dut_code() !== 0) begin n_errors++; $display("FAIL rst_code: got %0d exp 0", dut_code()); end
    if (bus.code_valid !== 1'b0) begin n_errors++; $display("FAIL rst_valid: got %b exp 0", bus.code_valid); end
    if (bus.overrun !== 1'b0) begin n_errors++; $display("FAIL rst_overrun: got %b exp 0", bus.overrun); end
    if (bus.busy !== 1'b0) begin n_errors++; $display("FAIL rst_busy: got %b exp 0", bus.busy); end
  endtask

  task automatic test_random();
    bit en, src, snk, cd, rdy, rst;
    for (int i = 0; i < 4000; i++) begin
      en  = ($urandom_range(0, 99) < 97);
      src = ($urandom_range(0, 99) < 55);
      snk = ($urandom_range(0, 99) < 40);
      cd  = ($urandom_range(0, 7) == 0);
      rdy = ($urandom_range(0, 99) < 30);
      rst = ($urandom_range(0, 999) == 0);
      tick(en, src, snk, cd, rdy, rst);
      n_checks += 4;
      if (bus.code_valid !== m_valid) begin
        n_errors++; $display("FAIL rand_valid @%0d: got %b exp %b", i, bus.code_valid, m_valid);
      end
      if (dut_code() !== m_code) begin
        n_errors++; $display("FAIL rand_code @%0d: got %0d exp %0d", i, dut_code(), m_code);
      end
      if (bus.overrun !== m_ovr) begin
        n_errors++; $display("FAIL rand_overrun @%0d: got %b exp %b", i, bus.overrun, m_ovr);
      end
      if (bus.busy !== m_busy) begin
        n_errors++; $display("FAIL rand_busy @%0d: got %b exp %b", i, bus.busy, m_busy);
      end
    end
  endtask

  initial begin
    bus.enable = 0; bus.src_evt = 0; bus.snk_evt = 0;
    bus.conv_done = 0; bus.code_ready = 0; reset = 1;
    m_running = 0; m_armed = 0; m_cur = 0; m_code = 0;
    m_valid = 0; m_ovr = 0; m_busy = 0;
    test_reset();
    test_basic();
    test_boundary();
    test_saturation();
    test_sync_discard();
    test_backpressure();
    test_disable();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/tmp_readout.md
# tmp_readout

Digital readout for the temperature front-end's charge-balancing loop. It counts source and sink pump events over a window of conversion frames and reduces them to one signed temperature code. Codes go to the register/host side through a valid/ready handshake. The block sits downstream of the front-end sequencer and consumes that sequencer's pump-event and conversion-done indications, already synchronised to `clk`.

## Interface
Parameters:
- `CNT_W`, 12: width of the per-frame signed up/down counter.
- `LOG_WIN`, 4: log2 of the number of frames summed per output code (window = 2^LOG_WIN).
- `DATA_W`, `CNT_W+LOG_WIN`: output code width; must be at least `CNT_W+LOG_WIN`. Codes are sign-extended into it.

Ports:
- `clk`, input, 1: sole clock, rising edge.
- `reset`, input, 1: synchronous, active-high; clears all state at the next rising edge of `clk`.
- `enable`, input, 1: run request; low forces IDLE.
- `src_evt`, input, 1: one-cycle strobe per source-pump event; counts +1.
- `snk_evt`, input, 1: one-cycle strobe per sink-pump event; counts −1.
- `conv_done`, input, 1: one-cycle strobe marking the end of a conversion frame.
- `code`, output, DATA_W: signed windowed sum of (src − snk).
- `code_valid`, output, 1: `code` holds an unread result.
- `code_ready`, input, 1: consumer accepts `code` when `code_valid` is also high.
- `overrun`, output, 1: sticky; at least one result was dropped.
- `busy`, output, 1: high in SYNC or ACC.

## Operation
- Reset values: `code`=0, `code_valid`=0, `overrun`=0, `busy`=0. Internally: state=IDLE, frame counter=0, accumulator=0, frame index=0.
- State IDLE:
  - Counters are held at 0.
  - `enable`=1 moves to SYNC.
- State SYNC:
  - Events are ignored and the counter is held at 0. This discards the partial frame in progress.
  - `conv_done` moves to ACC.
  - `enable`=0 returns to IDLE.
- State ACC, per-cycle counter update:
  - `src_evt` alone adds 1; `snk_evt` alone subtracts 1.
  - Both or neither: no change.
  - The counter saturates at +(2^(CNT_W−1)−1) and −(2^(CNT_W−1)−1); it never wraps.
- State ACC, on `conv_done`:
  - Closing frame value = counter plus this cycle's event delta. Events in the `conv_done` cycle belong to the closing frame.
  - The closing frame value is sign-extended and added to the accumulator; the counter clears to 0.
  - The frame index increments.
  - When the frame index reaches 2^LOG_WIN − 1 and `conv_done` arrives, the window completes: result = accumulator + closing frame value; accumulator and index clear.
- Accumulator sizing: width `CNT_W+LOG_WIN`. It cannot overflow given counter saturation, so no wrap handling is required.
- Result delivery on window completion:
  - If `code_valid`=0, or `code_valid`=1 with `code_ready`=1 in the same cycle: `code` loads the result and `code_valid`=1.
  - If `code_valid`=1 and `code_ready`=0: the result is dropped, `code` is unchanged, and `overrun` is set.
- Handshake:
  - A transfer occurs on any cycle with `code_valid`=1 and `code_ready`=1.
  - Without a new result that cycle, `code_valid` falls on the next cycle.
  - `code` is stable while `code_valid`=1 and no transfer has occurred.
- `overrun` clears only on `reset`.
- `enable`=0 in ACC or SYNC:
  - Returns to IDLE next cycle and clears counter, accumulator and index. The partial window is lost.
  - `code`, `code_valid` and `overrun` are retained, so a pending result can still be read.

## Timing
- Result latency: `code_valid` rises on the rising edge after the window-closing `conv_done` cycle (1 cycle).
- Window length from `enable`: first `conv_done` (sync), then 2^LOG_WIN further `conv_done` strobes.
- Back-to-back `conv_done` on consecutive cycles is legal. Each strobe closes a frame; an empty frame contributes 0.
- `busy` is a registered decode of state, updated on the same edge as the state change.
- Reset mid-window: the next edge forces IDLE and all outputs return to their reset values, regardless of inputs.
- Inputs are sampled only on rising `clk`. A strobe held high for N cycles counts as N events.

## Test plan
- Basic window: LOG_WIN=2, CNT_W=8. Enable, one sync `conv_done`, then 4 frames of 5 `src_evt` and 2 `snk_evt` each. Required: `code`=12 and `code_valid`=1 exactly 1 cycle after the 4th `conv_done`.
- Boundary events: `src_evt`+`snk_evt` together for 3 cycles, then `src_evt` in the same cycle as `conv_done`. Required: that frame contributes +1; simultaneous events contribute 0.
- Saturation: CNT_W=8 with 300 `src_evt` in one frame. Required: frame contributes +127; with 2^LOG_WIN=4 identical frames, `code`=508.
- Backpressure: hold `code_ready`=0 across two completed windows. Required: the first `code` is retained, `overrun`=1. Then raise `code_ready` in the cycle a third window completes. Required: `code_valid` stays high, `code` takes the third value, and no further overrun is recorded.
- Sync discard: 10 `src_evt` while in SYNC before the first `conv_done`. Required: excluded, so the first `code` equals only the ACC-phase sum.
- Reset/disable mid-window: drop `enable` after 2 frames. Required: IDLE, `busy`=0, no `code_valid`. Then assert `reset` with `code_valid`=1 and `overrun`=1. Required: next edge gives `code`=0, `code_valid`=0, `overrun`=0.
